// File: rtl/dmem_mmio_responder.sv
// Data-port responder for the pipelined core's M stage: word RAM plus a small MMIO bank
// (cycle counter, TOHOST mailbox, byte TX FIFO with valid/ready drain).
module dmem_mmio_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
);

  localparam int IDX_W = $clog2(RAM_WORDS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    REG_CYCLE  = 2'd0,
    REG_TOHOST = 2'd1,
    REG_TXDATA = 2'd2,
    REG_STATUS = 2'd3
  } mmioReg_t;

  logic [31:0]      ram [RAM_WORDS];
  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [31:0]      cycleCount;

  logic             isMmio;
  mmioReg_t         mmioSel;
  logic [IDX_W-1:0] ramIdx;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             pushReq;
  logic             pushAccept;
  logic             popAccept;
  logic             overflowSet;
  logic             overflowClear;
  logic             tohostWrite;
  logic [31:0]      statusWord;
  logic             unusedAddrBits;

  // Address decode: bit 31 splits RAM from MMIO; the bits in between alias.
  assign isMmio         = ALUResultM[31];
  assign mmioSel        = mmioReg_t'(ALUResultM[3:2]);
  assign ramIdx         = ALUResultM[IDX_W+1:2];
  assign unusedAddrBits = ^{ALUResultM[30:IDX_W+2], ALUResultM[1:0]};

  assign fifoFull  = (count == CNT_W'(FIFO_DEPTH));
  assign fifoEmpty = (count == '0);
  assign tx_valid  = !fifoEmpty;
  assign tx_data   = fifoMem[rdPtr];

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign pushReq       = MemWriteM && isMmio && (mmioSel == REG_TXDATA);
  assign popAccept     = tx_valid && tx_ready;
  assign pushAccept    = pushReq && (!fifoFull || popAccept);
  assign overflowSet   = pushReq && fifoFull && !popAccept;
  assign overflowClear = MemWriteM && isMmio && (mmioSel == REG_STATUS) && WriteDataM[2];
  assign tohostWrite   = MemWriteM && isMmio && (mmioSel == REG_TOHOST);

  assign statusWord = {24'b0, 4'(count), 1'b0, overflow, fifoEmpty, fifoFull};

  // Combinational load path so the core gets its data in the same M cycle.
  always_comb begin
    ReadDataM = '0;
    if (!isMmio) begin
      ReadDataM = ram[ramIdx];
    end else begin
      unique case (mmioSel)
        REG_CYCLE:  ReadDataM = cycleCount;
        REG_TOHOST: ReadDataM = tohost_data;
        REG_TXDATA: ReadDataM = '0;
        REG_STATUS: ReadDataM = statusWord;
      endcase
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (MemWriteM && !isMmio) begin
      ram[ramIdx] <= WriteDataM;
    end
  end

  always_ff @(posedge clk) begin
    if (pushAccept) begin
      fifoMem[wrPtr] <= WriteDataM[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCount <= '0;
    end else begin
      cycleCount <= cycleCount + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
    end else if (tohostWrite) begin
      tohost_valid <= 1'b1;
      tohost_data  <= WriteDataM;
    end
  end

  // Pointer/count bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pushAccept) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (popAccept) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      if (pushAccept && !popAccept) begin
        count <= count + CNT_W'(1);
      end else if (popAccept && !pushAccept) begin
        count <= count - CNT_W'(1);
      end
      if (overflowSet) begin
        overflow <= 1'b1;
      end else if (overflowClear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
